// File: rtl/params_pkg.sv
// Shared widths, reset PC and FSM state type for the instruction fetch path.
package params_pkg;

    localparam int          ADDR_WIDTH  = 32;
    localparam int          INSTR_WIDTH = 32;
    localparam logic [31:0] RESET_PC    = 32'h0000_1000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_FLUSH
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch controller with a one-entry decode buffer.
// Redirects re-steer the PC in any state; responses orphaned by a redirect are dropped and counted.
module fetch_ctrl #(
    parameter int                    ADDR_WIDTH  = params_pkg::ADDR_WIDTH,
    parameter int                    INSTR_WIDTH = params_pkg::INSTR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(params_pkg::RESET_PC)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic                   redirect_i,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
    output logic                   imem_req_o,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    input  logic                   imem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    output logic                   dec_valid_o,
    input  logic                   dec_ready_i,
    output logic [INSTR_WIDTH-1:0] dec_instr_o,
    output logic [ADDR_WIDTH-1:0]  dec_pc_o,
    output logic [15:0]            flush_cnt_o
);
    import params_pkg::*;

    fetch_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  dec_pc_q, dec_pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [15:0]            flush_cnt_q, flush_cnt_d;
    logic                   drop;
    logic [ADDR_WIDTH-1:0]  redirect_tgt;
    logic                   unused_pc_lsbs;

    // Instructions are word aligned, so the low target bits carry no information.
    assign redirect_tgt   = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
    assign unused_pc_lsbs = ^redirect_pc_i[1:0];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        dec_pc_d = dec_pc_q;
        instr_d  = instr_q;
        drop     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (en_i && !redirect_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_rvalid_i) begin
                    if (redirect_i) begin
                        // Response belongs to the old path; refetch straight away at the target.
                        drop = 1'b1;
                    end else begin
                        instr_d  = imem_rdata_i;
                        dec_pc_d = pc_q;
                        pc_d     = pc_q + ADDR_WIDTH'(4);
                        state_d  = S_HOLD;
                    end
                end else if (redirect_i) begin
                    state_d = S_FLUSH;
                end
            end
            S_HOLD: begin
                if (redirect_i)       state_d = S_FETCH;
                else if (dec_ready_i) state_d = en_i ? S_FETCH : S_IDLE;
            end
            S_FLUSH: begin
                // Wait out the orphaned response before issuing on the new path.
                if (imem_rvalid_i) begin
                    drop    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (redirect_i) pc_d = redirect_tgt;

        flush_cnt_d = flush_cnt_q;
        if (drop && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            dec_pc_q    <= '0;
            instr_q     <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            dec_pc_q    <= dec_pc_d;
            instr_q     <= instr_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign imem_req_o  = (state_q == S_FETCH);
    assign imem_addr_o = pc_q;
    assign dec_valid_o = (state_q == S_HOLD) && !redirect_i;
    assign dec_instr_o = instr_q;
    assign dec_pc_o    = dec_pc_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
